// File: rtl/tsl1401_scan_sched_pkg.sv
// Shared types and constants for the TSL1401 linear-sensor scan scheduler.
`timescale 1ns/1ps
package tsl1401_pkg;

  localparam int NPIX_DEFAULT = 128;
  localparam int PIX_W        = 7;

  typedef enum logic [3:0] {
    IDLE,
    SI_SETUP,
    SI_HIGH,
    SETTLE,
    TRIG,
    ADC_WAIT,
    CLK_LOW,
    TAIL_HIGH,
    TAIL_LOW,
    END,
    INTEG
  } state_e;

endpackage

// File: rtl/tsl1401_scan_sched_tick_cnt.sv
// Reloadable down-counter; a state lasting D cycles loads D-1 on entry and leaves when zero is seen.
`timescale 1ns/1ps
module tsl1401_tick_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tsl1401_scan_sched.sv
// TSL1401 SI/CLK sequencer that parks the sensor clock high until the ADC reports each pixel converted.
`timescale 1ns/1ps
module tsl1401_scan_sched
  import tsl1401_pkg::*;
#(
  parameter int NPIX         = NPIX_DEFAULT,
  parameter int HALF_TICKS   = 5,
  parameter int SETTLE_TICKS = 3,
  parameter int ADC_TIMEOUT  = 255,
  parameter int INT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic [INT_W-1:0] int_ticks,
  input  logic             adc_done,
  output logic             sensor_clk,
  output logic             sensor_si,
  output logic             adc_trig,
  output logic [PIX_W-1:0] pix_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout
);

  localparam int CW = (INT_W > 16) ? INT_W : 16;
  localparam logic [CW-1:0]    HALF_M1   = CW'(HALF_TICKS - 1);
  localparam logic [CW-1:0]    SETTLE_M1 = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0]    TMO_M1    = CW'(ADC_TIMEOUT - 1);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NPIX - 1);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             err_q, err_d;
  logic             tick_load, tick_zero;
  logic [CW-1:0]    tick_val;

  logic             sensor_clk_q, sensor_clk_d;
  logic             sensor_si_q, sensor_si_d;
  logic             adc_trig_q, adc_trig_d;
  logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  tsl1401_tick_cnt #(.W(CW)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (tick_load),
    .load_val (tick_val),
    .zero     (tick_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pix_q        <= '0;
      err_q        <= 1'b0;
      sensor_clk_q <= 1'b0;
      sensor_si_q  <= 1'b0;
      adc_trig_q   <= 1'b0;
      pix_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      err_q        <= err_d;
      sensor_clk_q <= sensor_clk_d;
      sensor_si_q  <= sensor_si_d;
      adc_trig_q   <= adc_trig_d;
      pix_idx_q    <= pix_idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    err_d     = err_q;
    tick_load = 1'b0;
    tick_val  = HALF_M1;
    case (state_q)
      IDLE: if (start) begin
        state_d = SI_SETUP; tick_load = 1'b1; pix_d = '0; err_d = 1'b0;
      end
      SI_SETUP: if (tick_zero) begin
        state_d = SI_HIGH; tick_load = 1'b1;
      end
      SI_HIGH: if (tick_zero) begin
        state_d = SETTLE; tick_load = 1'b1; tick_val = SETTLE_M1;
      end
      SETTLE: if (tick_zero) state_d = TRIG;
      TRIG: begin
        state_d = ADC_WAIT; tick_load = 1'b1; tick_val = TMO_M1;
      end
      // A timeout is treated exactly like a late adc_done, apart from the sticky flag.
      ADC_WAIT: if (adc_done || tick_zero) begin
        state_d = CLK_LOW; tick_load = 1'b1;
        if (!adc_done) err_d = 1'b1;
      end
      CLK_LOW: if (tick_zero) begin
        tick_load = 1'b1;
        if (pix_q == LAST_PIX) begin
          state_d = TAIL_HIGH;
        end else begin
          state_d = SETTLE; tick_val = SETTLE_M1; pix_d = pix_q + PIX_W'(1);
        end
      end
      TAIL_HIGH: if (tick_zero) begin
        state_d = TAIL_LOW; tick_load = 1'b1;
      end
      TAIL_LOW: if (tick_zero) state_d = END;
      // int_ticks is captured into the counter here, so later changes wait for the next frame end.
      END: begin
        if (!cont) begin
          state_d = IDLE;
        end else if (int_ticks == '0) begin
          state_d = SI_SETUP; tick_load = 1'b1; pix_d = '0;
        end else begin
          state_d = INTEG; tick_load = 1'b1; tick_val = CW'(int_ticks) - CW'(1);
        end
      end
      INTEG: if (tick_zero) begin
        state_d = SI_SETUP; tick_load = 1'b1; pix_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sensor_clk_d = 1'b0;
    sensor_si_d  = 1'b0;
    adc_trig_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_q != IDLE);
    pix_idx_d    = pix_idx_q;
    case (state_q)
      SI_SETUP: begin sensor_si_d = 1'b1; pix_idx_d = '0; end
      SI_HIGH:  begin sensor_si_d = 1'b1; sensor_clk_d = 1'b1; end
      SETTLE, ADC_WAIT, TAIL_HIGH: sensor_clk_d = 1'b1;
      TRIG:     begin sensor_clk_d = 1'b1; adc_trig_d = 1'b1; pix_idx_d = pix_q; end
      END:      frame_done_d = 1'b1;
      default:  ;
    endcase
  end

  assign sensor_clk  = sensor_clk_q;
  assign sensor_si   = sensor_si_q;
  assign adc_trig    = adc_trig_q;
  assign pix_idx     = pix_idx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err_timeout = err_q;

endmodule

// File: doc/tsl1401_scan_sched.md
Name: tsl1401_scan_sched

Overview:
Scan scheduler for the TSL1401 128-pixel linear sensor. It generates the sensor SI/CLK waveform and holds the clock after each rising edge until the MCU ADC has converted the pixel, using an adc_trig/adc_done handshake. It runs single-shot or continuous frames, with a programmable integration gap between frames. It sits between the MCU-facing control registers and the sensor pins, in place of free-running sequencing.

Parameters:
NPIX, 128, pixels per frame (sensor clock rising edges = NPIX+1)
HALF_TICKS, 5, system clocks per sensor_clk half-period (>=1)
SETTLE_TICKS, 3, system clocks from sensor_clk rise to adc_trig (analog settle, >=1)
ADC_TIMEOUT, 255, max system clocks waiting for adc_done
INT_W, 16, width of integration-gap count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a frame
cont  in  1  continuous mode; sampled at frame end
int_ticks  in  INT_W  integration gap in system clocks; latched on start and at each frame end
adc_done  in  1  ADC conversion complete, single-cycle pulse
sensor_clk  out  1  sensor CLK pin, registered
sensor_si  out  1  sensor SI pin, registered
adc_trig  out  1  one-cycle ADC start pulse
pix_idx  out  7  pixel index for the current adc_trig, 0..NPIX-1
busy  out  1  high from frame start until return to IDLE
frame_done  out  1  one-cycle pulse after the (NPIX+1)th clock falls
err_timeout  out  1  sticky; set on ADC timeout, cleared by start

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0. Reset mid-frame aborts the frame immediately with sensor_clk=0 and sensor_si=0. No frame_done is issued.
- All outputs are registered. Start accepted in IDLE at edge N gives busy=1 and sensor_si=1 at edge N+1.
- start while not IDLE is ignored.
- States and transitions:
  - IDLE -> SI_SETUP on start.
  - SI_SETUP: si=1, clk=0, for HALF_TICKS cycles.
  - SI_HIGH: clk=1, si=1, for HALF_TICKS cycles; this is rising edge 0.
  - SETTLE: clk=1, si=0, for SETTLE_TICKS cycles.
  - TRIG: adc_trig=1 for one cycle, with pix_idx = current pixel.
  - ADC_WAIT: clk held high until adc_done.
  - CLK_LOW: clk=0 for HALF_TICKS cycles.
  - If pix_idx < NPIX-1: pixel+1, clk rises, go to SETTLE.
  - Else TAIL_HIGH: clk=1 for HALF_TICKS (edge NPIX, no trig), then TAIL_LOW: clk=0 for HALF_TICKS.
  - Then END: frame_done=1 for one cycle; relatch int_ticks.
  - END -> INTEG if cont=1, else -> IDLE.
  - INTEG waits int_ticks cycles, then -> SI_SETUP. With int_ticks=0, go directly to SI_SETUP.
- SI rule: si falls on the same edge it is sampled high; si=1 and clk=1 overlap for exactly HALF_TICKS cycles.
- Handshake:
  - adc_done is sampled only in ADC_WAIT, from the cycle after TRIG. adc_done arriving in any other state is ignored.
  - If ADC_TIMEOUT cycles elapse in ADC_WAIT: set err_timeout and proceed as if done.
- Clearing cont mid-frame finishes the current frame, then goes to IDLE. Setting cont during INTEG has no effect until the next END.
- pix_idx holds its last value between triggers and resets to 0 at SI_SETUP. pix_idx never exceeds NPIX-1.
- busy stays 1 through INTEG. busy=0 only in IDLE.

Decomposition:
- Package tsl1401_pkg holds the state enum (IDLE, SI_SETUP, SI_HIGH, SETTLE, TRIG, ADC_WAIT, CLK_LOW, TAIL_HIGH, TAIL_LOW, END, INTEG), NPIX_DEFAULT, and the pixel index width (7).
- One sub-module, tsl1401_tick_cnt: a reloadable down-counter with load value, load strobe and zero flag. It is shared for the HALF_TICKS, SETTLE_TICKS, ADC_TIMEOUT and int_ticks timing.
- The FSM lives in the top.

Test Plan:
- Single frame: HALF_TICKS=2, SETTLE_TICKS=1, cont=0, and a model that returns adc_done 4 cycles after adc_trig. Pulse start -> exactly 129 sensor_clk rising edges and 128 adc_trig pulses with pix_idx 0..127 in order; one frame_done; busy returns to 0; sensor_si high for exactly 4 cycles.
- Continuous mode: cont=1, int_ticks=20. Measure from frame_done to the next sensor_si rise -> 20 cycles (INTEG) plus 1; three frames back-to-back. Drop cont during frame 3 -> IDLE after its frame_done.
- ADC stall and timeout: hold adc_done=0 on pixel 5 -> sensor_clk stays high for ADC_TIMEOUT cycles; err_timeout=1 (sticky); the frame completes with 128 triggers. Next start clears err_timeout.
- Spurious inputs: start pulsed while busy, and adc_done pulsed in SETTLE/CLK_LOW/IDLE -> no effect on the trigger count or timing.
- Async reset at pixel 64 while sensor_clk=1 -> sensor_clk, sensor_si, busy and adc_trig go 0 without waiting for a clock edge; no frame_done. A new start after release yields a full 128-pixel frame starting at pix_idx 0.
